alu_seq: RTL and testbench

- Parametrised, registered successor to the CPU's 8-bit combinational ALU.
- Adds SUB, iterative shifts and an iterative multiply.
- Uses a valid/ready input handshake and a one-cycle DONE pulse.
- Flags ZERO, CARRY and NEG are updated for every operation. It sits between the register file and the writeback mux; the control unit stalls the PC while IN_READY is low.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_iter_core.sv | 134 +++++++++++++
 rtl/alu_seq.sv | 174 +++++++++++++++++
 tb/tb_alu_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode values, FSM state encoding and iterative-core
// mode encoding for the alu_seq sequential ALU.
package alu_pkg;

  // Opcodes carried on SELECT
  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  // Top-level control states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Operation performed by the iterative core
  typedef enum logic [1:0] {
    IT_SLL = 2'b00,
    IT_SRA = 2'b01,
    IT_MUL = 2'b10
  } iter_mode_e;

endpackage

// File: rtl/alu_iter_core.sv
// alu_iter_core: multi-cycle engine for SLL, SRA (one bit per cycle) and
// unsigned shift-add MUL (one multiplier bit per cycle, WIDTH steps).
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   start_i        load operands and begin iterating (only when idle)
//   mode_i         operation to perform
//   a_i, b_i       operand A (value to shift / multiplicand), operand B (multiplier)
//   n_i            shift amount (must be non-zero for shifts)
//   done_iter_o    high in the cycle whose rising edge performs the last step
//   value_o        result produced by the step taken at that edge
//   carry_o        carry/shift-out/overflow produced by that step
// The final step's value is presented combinationally so the owner can
// register the result on the same edge the last iteration happens.
module alu_iter_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_i,
  input  iter_mode_e               mode_i,
  input  logic [WIDTH-1:0]         a_i,
  input  logic [WIDTH-1:0]         b_i,
  input  logic [$clog2(WIDTH)-1:0] n_i,
  output logic                     done_iter_o,
  output logic [WIDTH-1:0]         value_o,
  output logic                     carry_o
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MUL = CW'(WIDTH);

  // acc_q: shift value, or high half of the running product for MUL.
  // mq_q : multiplier, shifting right as product low bits enter from the top.
  logic             busy_q, busy_d;
  iter_mode_e       mode_q, mode_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] acc_step_s;
  logic [WIDTH-1:0] mq_step_s;
  logic             carry_step_s;
  logic [WIDTH:0]   sum_s;

  // One iteration step of the current operation
  always_comb begin
    acc_step_s   = acc_q;
    mq_step_s    = mq_q;
    carry_step_s = 1'b0;
    sum_s        = {(WIDTH+1){1'b0}};
    case (mode_q)
      IT_SLL: begin
        acc_step_s   = {acc_q[WIDTH-2:0], 1'b0};
        carry_step_s = acc_q[WIDTH-1];
      end
      IT_SRA: begin
        acc_step_s   = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
        carry_step_s = acc_q[0];
      end
      IT_MUL: begin
        // Add multiplicand when the current multiplier bit is set, then
        // shift the {high, low} product pair right by one.
        sum_s        = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        acc_step_s   = sum_s[WIDTH:1];
        mq_step_s    = {sum_s[0], mq_q[WIDTH-1:1]};
        carry_step_s = |sum_s[WIDTH:1];
      end
      default: begin
        acc_step_s   = acc_q;
        mq_step_s    = mq_q;
        carry_step_s = 1'b0;
      end
    endcase
  end

  // Next-state for the accumulators and the iteration counter
  always_comb begin
    busy_d  = busy_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    if (start_i) begin
      busy_d  = 1'b1;
      mode_d  = mode_i;
      mcand_d = a_i;
      mq_d    = b_i;
      if (mode_i == IT_MUL) begin
        acc_d = {WIDTH{1'b0}};
        cnt_d = CNT_MUL;
      end else begin
        acc_d = a_i;
        cnt_d = {1'b0, n_i};
      end
    end else if (busy_q) begin
      acc_d  = acc_step_s;
      mq_d   = mq_step_s;
      cnt_d  = cnt_q - CNT_ONE;
      busy_d = (cnt_q != CNT_ONE);
    end else begin
      busy_d = 1'b0;
    end
  end

  // Iteration state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= 1'b0;
      mode_q  <= IT_SLL;
      acc_q   <= {WIDTH{1'b0}};
      mq_q    <= {WIDTH{1'b0}};
      mcand_q <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
    end else begin
      busy_q  <= busy_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

  assign done_iter_o = busy_q & (cnt_q == CNT_ONE);
  assign value_o     = (mode_q == IT_MUL) ? mq_step_s : acc_step_s;
  assign carry_o     = carry_step_s;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready request handshake and a
// one-cycle DONE pulse. Simple ops complete on the accept edge; non-zero
// shifts and MUL run in alu_iter_core while IN_READY is low.
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   DATA1, DATA2      operands (DATA2 low bits are the shift amount)
//   SELECT            opcode (see alu_pkg)
//   IN_VALID/IN_READY request handshake; accept when both high at an edge
//   RESULT            registered result, held until the next DONE
//   DONE              one-cycle pulse when RESULT and flags are new
//   ZERO, CARRY, NEG  registered flags for RESULT
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [2:0]       SELECT,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic             DONE,
  output logic             ZERO,
  output logic             CARRY,
  output logic             NEG
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             neg_q, neg_d;

  logic [WIDTH-1:0] sc_result_s;
  logic             sc_carry_s;
  logic             is_iter_s;
  iter_mode_e       iter_mode_s;
  logic [WIDTH:0]   add_s;
  logic [SHW-1:0]   shamt_s;
  logic             start_iter_s;

  logic             done_iter_s;
  logic [WIDTH-1:0] iter_value_s;
  logic             iter_carry_s;

  assign shamt_s = DATA2[SHW-1:0];

  // Single-cycle datapath and classification of multi-cycle requests
  always_comb begin
    sc_result_s = DATA2;
    sc_carry_s  = 1'b0;
    is_iter_s   = 1'b0;
    iter_mode_s = IT_SLL;
    add_s       = {1'b0, DATA1} + {1'b0, DATA2};
    case (SELECT)
      OP_FWD: sc_result_s = DATA2;
      OP_ADD: {sc_carry_s, sc_result_s} = add_s;
      OP_AND: sc_result_s = DATA1 & DATA2;
      OP_OR:  sc_result_s = DATA1 | DATA2;
      OP_SUB: begin
        sc_result_s = DATA1 - DATA2;
        sc_carry_s  = (DATA1 >= DATA2);
      end
      OP_SLL: begin
        // A zero shift finishes immediately with the operand unchanged.
        sc_result_s = DATA1;
        is_iter_s   = |shamt_s;
        iter_mode_s = IT_SLL;
      end
      OP_SRA: begin
        sc_result_s = DATA1;
        is_iter_s   = |shamt_s;
        iter_mode_s = IT_SRA;
      end
      OP_MUL: begin
        if (MUL_EN) begin
          is_iter_s   = 1'b1;
          iter_mode_s = IT_MUL;
        end else begin
          sc_result_s = DATA2;
        end
      end
      default: sc_result_s = DATA2;
    endcase
  end

  assign start_iter_s = (state_q == ST_IDLE) & IN_VALID & is_iter_s;

  alu_iter_core #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk         (CLK),
    .reset       (RESET),
    .start_i     (start_iter_s),
    .mode_i      (iter_mode_s),
    .a_i         (DATA1),
    .b_i         (DATA2),
    .n_i         (shamt_s),
    .done_iter_o (done_iter_s),
    .value_o     (iter_value_s),
    .carry_o     (iter_carry_s)
  );

  // FSM next state and output/flag register loads
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (IN_VALID) begin
          if (is_iter_s) begin
            state_d = ST_RUN;
          end else begin
            result_d = sc_result_s;
            carry_d  = sc_carry_s;
            done_d   = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Outputs stay untouched until the core's final step.
        if (done_iter_s) begin
          result_d = iter_value_s;
          carry_d  = iter_carry_s;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    zero_d = ~|result_d;
    neg_d  = result_d[WIDTH-1];
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      result_q <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      neg_q    <= neg_d;
    end
  end

  assign IN_READY = (state_q == ST_IDLE);
  assign RESULT   = result_q;
  assign DONE     = done_q;
  assign ZERO     = zero_q;
  assign CARRY    = carry_q;
  assign NEG      = neg_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=8, MUL_EN=1).
// Directed vector table, hand-written multi-cycle sequences, and random
// operations checked against an arithmetic reference model.
module tb_alu_seq;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] DATA1;
  logic [7:0] DATA2;
  logic [2:0] SELECT;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] RESULT;
  logic       DONE;
  logic       ZERO;
  logic       CARRY;
  logic       NEG;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(
    .WIDTH  (8),
    .MUL_EN (1'b1)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .DATA1    (DATA1),
    .DATA2    (DATA2),
    .SELECT   (SELECT),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .RESULT   (RESULT),
    .DONE     (DONE),
    .ZERO     (ZERO),
    .CARRY    (CARRY),
    .NEG      (NEG)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    int         lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode definitions.
  function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] r, output logic c, output int lat);
    int ai = int'(a);
    int bi = int'(b);
    int n  = int'(b[2:0]);
    int p;
    int sa;
    r = 8'h00; c = 1'b0; lat = 0; p = 0;
    case (op)
      3'd0: r = b;
      3'd1: begin p = ai + bi; r = p[7:0]; c = (p > 255); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: begin p = ai - bi; r = p[7:0]; c = (ai >= bi); end
      3'd5: begin p = ai << n; r = p[7:0]; c = (n > 0) ? p[8] : 1'b0; lat = n; end
      3'd6: begin
        sa = a[7] ? ai - 256 : ai;
        p  = sa >>> n;
        r  = p[7:0];
        c  = (n > 0) ? (((ai >> (n - 1)) & 1) == 1) : 1'b0;
        lat = n;
      end
      3'd7: begin p = ai * bi; r = p[7:0]; c = ((p >> 8) != 0); lat = 8; end
      default: r = 8'h00;
    endcase
  endfunction

  // Issue one request, then verify latency, ready behaviour, result and flags.
  task automatic do_op(input string name, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] er, input logic ec, input int lat);
    int cyc;
    @(negedge CLK);
    check({name, " ready_before"}, 32'(IN_READY), 32'd1);
    SELECT = op; DATA1 = a; DATA2 = b; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    // Scramble inputs after accept: captured operands must be used.
    IN_VALID = 1'b0; DATA1 = 8'($urandom); DATA2 = 8'($urandom); SELECT = 3'($urandom);
    cyc = 0;
    while (DONE !== 1'b1 && cyc < 40) begin
      check({name, " ready_low"}, 32'(IN_READY), 32'd0);
      @(posedge CLK); #1;
      cyc++;
    end
    check({name, " latency"}, 32'(cyc), 32'(lat));
    check({name, " result"}, 32'(RESULT), 32'(er));
    check({name, " carry"}, 32'(CARRY), 32'(ec));
    check({name, " zero"}, 32'(ZERO), 32'(er == 8'h00));
    check({name, " neg"}, 32'(NEG), 32'(er[7]));
    check({name, " ready_at_done"}, 32'(IN_READY), 32'd1);
    @(posedge CLK); #1;
    check({name, " done_single"}, 32'(DONE), 32'd0);
  endtask

  initial begin
    vec_t       vecs[$];
    logic [2:0] op;
    logic [7:0] a, b, er;
    logic       ec;
    int         lat;
    int         done_cnt;

    RESET = 1'b1; IN_VALID = 1'b0; DATA1 = 8'h00; DATA2 = 8'h00; SELECT = 3'd0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    check("rst result", 32'(RESULT), 32'h00);
    check("rst zero", 32'(ZERO), 32'd1);
    check("rst carry", 32'(CARRY), 32'd0);
    check("rst neg", 32'(NEG), 32'd0);
    check("rst ready", 32'(IN_READY), 32'd1);
    check("rst done", 32'(DONE), 32'd0);

    // Directed vectors: op, a, b, result, carry, latency
    vecs.push_back('{3'd1, 8'hFF, 8'h01, 8'h00, 1'b1, 0});
    vecs.push_back('{3'd4, 8'h05, 8'h07, 8'hFE, 1'b0, 0});
    vecs.push_back('{3'd6, 8'h90, 8'h03, 8'hF2, 1'b0, 3});
    vecs.push_back('{3'd5, 8'h81, 8'h00, 8'h81, 1'b0, 0});
    vecs.push_back('{3'd7, 8'h13, 8'h11, 8'h43, 1'b1, 8});
    vecs.push_back('{3'd7, 8'h0F, 8'h0F, 8'hE1, 1'b0, 8});
    vecs.push_back('{3'd0, 8'h12, 8'h34, 8'h34, 1'b0, 0});
    vecs.push_back('{3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 0});
    vecs.push_back('{3'd3, 8'hF0, 8'h0C, 8'hFC, 1'b0, 0});
    vecs.push_back('{3'd4, 8'h07, 8'h05, 8'h02, 1'b1, 0});
    vecs.push_back('{3'd4, 8'h05, 8'h05, 8'h00, 1'b1, 0});
    vecs.push_back('{3'd5, 8'h81, 8'h01, 8'h02, 1'b1, 1});
    vecs.push_back('{3'd5, 8'h02, 8'hFF, 8'h00, 1'b1, 7});
    vecs.push_back('{3'd6, 8'h80, 8'h07, 8'hFF, 1'b0, 7});
    vecs.push_back('{3'd6, 8'h03, 8'h01, 8'h01, 1'b1, 1});
    vecs.push_back('{3'd7, 8'hFF, 8'hFF, 8'h01, 1'b1, 8});
    vecs.push_back('{3'd7, 8'h00, 8'hA5, 8'h00, 1'b0, 8});
    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].res, vecs[i].c, vecs[i].lat);

    // Back-to-back single-cycle requests
    @(negedge CLK);
    SELECT = 3'd1; DATA1 = 8'hFF; DATA2 = 8'h01; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    check("b2b add done", 32'(DONE), 32'd1);
    check("b2b add result", 32'(RESULT), 32'h00);
    check("b2b add zero", 32'(ZERO), 32'd1);
    check("b2b add carry", 32'(CARRY), 32'd1);
    check("b2b ready", 32'(IN_READY), 32'd1);
    SELECT = 3'd4; DATA1 = 8'h05; DATA2 = 8'h07;
    @(posedge CLK); #1;
    check("b2b sub done", 32'(DONE), 32'd1);
    check("b2b sub result", 32'(RESULT), 32'hFE);
    check("b2b sub carry", 32'(CARRY), 32'd0);
    check("b2b sub neg", 32'(NEG), 32'd1);
    IN_VALID = 1'b0;
    @(posedge CLK); #1;
    check("b2b idle done", 32'(DONE), 32'd0);
    check("b2b hold result", 32'(RESULT), 32'hFE);

    // MUL with input disturbance during RUN, then a held request
    @(negedge CLK);
    SELECT = 3'd7; DATA1 = 8'h13; DATA2 = 8'h11; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    check("mulint run ready", 32'(IN_READY), 32'd0);
    for (int i = 1; i < 8; i++) begin
      SELECT = 3'($urandom); DATA1 = 8'($urandom); DATA2 = 8'($urandom); IN_VALID = i[0];
      @(posedge CLK); #1;
      check("mulint no_done", 32'(DONE), 32'd0);
      check("mulint hold result", 32'(RESULT), 32'hFE);
    end
    SELECT = 3'd1; DATA1 = 8'h02; DATA2 = 8'h03; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    check("mulint done", 32'(DONE), 32'd1);
    check("mulint result", 32'(RESULT), 32'h43);
    check("mulint carry", 32'(CARRY), 32'd1);
    check("mulint ready", 32'(IN_READY), 32'd1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    check("held add done", 32'(DONE), 32'd1);
    check("held add result", 32'(RESULT), 32'h05);
    check("held add carry", 32'(CARRY), 32'd0);
    @(posedge CLK); #1;
    check("held add single", 32'(DONE), 32'd0);

    // Reset in the middle of a MUL
    @(negedge CLK);
    SELECT = 3'd7; DATA1 = 8'h13; DATA2 = 8'h11; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    check("abort result", 32'(RESULT), 32'h00);
    check("abort zero", 32'(ZERO), 32'd1);
    check("abort carry", 32'(CARRY), 32'd0);
    check("abort neg", 32'(NEG), 32'd0);
    check("abort ready", 32'(IN_READY), 32'd1);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (DONE === 1'b1) done_cnt++;
      @(posedge CLK); #1;
    end
    check("abort no_done", 32'(done_cnt), 32'd0);
    do_op("post_abort add", 3'd1, 8'h02, 8'h03, 8'h05, 1'b0, 0);

    // Random requests against the reference model
    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = 8'($urandom);
      model(op, a, b, er, ec, lat);
      do_op($sformatf("rnd%0d op%0d", i, op), op, a, b, er, ec, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
